better_neighbor_scan: RTL and testbench

Scans the neighbour Q-value table in the shared node memory and builds the betterNeighbors list plus betterNeighborCount, i.e. every neighbour whose qValue is strictly greater than the node's own Q-value. It is the bus master placed directly in front of `mem`. It drives `mem`'s address, wr_en and data_in, and consumes its combinational 16-bit big-endian data_out. The routing controller starts it once per decision round.

---
 rtl/node_mem_pkg.sv | 13 +
 rtl/better_neighbor_scan.sv | 129 ++++++++++++
 tb/tb_better_neighbor_scan.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/node_mem_pkg.sv
// node_mem_pkg: shared node-memory address map, word geometry and scan FSM states
package node_mem_pkg;
  localparam int WORD_WIDTH = 16;
  localparam int MEM_DEPTH = 2048;
  localparam logic [15:0] BASE_NBR_ID = 16'h0048;
  localparam logic [15:0] BASE_QVALUE = 16'h01C8;
  localparam logic [15:0] BASE_BETTER_NBR = 16'h0668;
  localparam logic [15:0] BASE_NBR_CNT = 16'h068A;
  localparam logic [15:0] BASE_BETTER_CNT = 16'h068C;
  localparam int NBR_DEPTH = 64;
  localparam int BETTER_DEPTH = 16;
  typedef enum logic [2:0] {IDLE, RD_CNT, RD_Q, RD_ID, WR_BN, WR_CNT, DONE} scan_state_t;
endpackage

// File: rtl/better_neighbor_scan.sv
// better_neighbor_scan: bus master collecting neighbours whose qValue beats own_q
module better_neighbor_scan
  import node_mem_pkg::*;
#(
  parameter logic [15:0] ADDR_NBR_ID = BASE_NBR_ID,
  parameter logic [15:0] ADDR_QVALUE = BASE_QVALUE,
  parameter logic [15:0] ADDR_BETTER_NBR = BASE_BETTER_NBR,
  parameter logic [15:0] ADDR_NBR_CNT = BASE_NBR_CNT,
  parameter logic [15:0] ADDR_BETTER_CNT = BASE_BETTER_CNT,
  parameter int MAX_NBR = NBR_DEPTH,
  parameter int MAX_BETTER = BETTER_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] own_q,
  output logic        busy,
  output logic        done,
  output logic [4:0]  better_count,
  output logic        overflow,
  output logic [15:0] mem_address,
  output logic        mem_wr_en,
  output logic [15:0] mem_data_in,
  input  logic [15:0] mem_data_out
);
  localparam logic [6:0] NMAX = 7'(MAX_NBR);
  localparam logic [4:0] BMAX = 5'(MAX_BETTER);
  scan_state_t state, state_n;
  logic [6:0] i, i_n, n, n_n, i_inc;
  logic [4:0] c, c_n, cnt_n;
  logic [15:0] q, q_n, id, id_n, addr_n, din_n;
  logic wr_n, ovf_n, better;
  assign i_inc = i + 7'd1;
  assign better = mem_data_out > q;
  assign busy = state != IDLE && state != DONE;
  assign done = state == DONE;
  always_comb begin
    state_n = state;
    i_n = i;
    c_n = c;
    n_n = n;
    q_n = q;
    id_n = id;
    ovf_n = overflow;
    cnt_n = better_count;
    case (state)
      IDLE: if (start) begin
        q_n = own_q;
        i_n = '0;
        c_n = '0;
        ovf_n = 1'b0;
        state_n = RD_CNT;
      end
      RD_CNT: begin
        n_n = mem_data_out > 16'(MAX_NBR) ? NMAX : mem_data_out[6:0];
        state_n = n_n == '0 ? WR_CNT : RD_Q;
      end
      RD_Q: if (better && c < BMAX) state_n = RD_ID;
      else begin
        ovf_n = overflow | better;
        i_n = i_inc;
        state_n = i_inc == n ? WR_CNT : RD_Q;
      end
      RD_ID: begin
        id_n = mem_data_out;
        state_n = WR_BN;
      end
      WR_BN: begin
        c_n = c + 5'd1;
        i_n = i_inc;
        state_n = i_inc == n ? WR_CNT : RD_Q;
      end
      WR_CNT: begin
        cnt_n = c;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  // bus is registered from the upcoming state so each read settles within its own cycle
  always_comb begin
    addr_n = '0;
    wr_n = 1'b0;
    din_n = '0;
    case (state_n)
      RD_CNT: addr_n = ADDR_NBR_CNT;
      RD_Q: addr_n = ADDR_QVALUE + {8'b0, i_n, 1'b0};
      RD_ID: addr_n = ADDR_NBR_ID + {8'b0, i_n, 1'b0};
      WR_BN: begin
        addr_n = ADDR_BETTER_NBR + {10'b0, c_n, 1'b0};
        wr_n = 1'b1;
        din_n = id_n;
      end
      WR_CNT: begin
        addr_n = ADDR_BETTER_CNT;
        wr_n = 1'b1;
        din_n = {11'b0, c_n};
      end
      default: addr_n = '0;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      c <= '0;
      n <= '0;
      q <= '0;
      id <= '0;
      overflow <= 1'b0;
      better_count <= '0;
      mem_address <= '0;
      mem_wr_en <= 1'b0;
      mem_data_in <= '0;
    end else begin
      state <= state_n;
      i <= i_n;
      c <= c_n;
      n <= n_n;
      q <= q_n;
      id <= id_n;
      overflow <= ovf_n;
      better_count <= cnt_n;
      mem_address <= addr_n;
      mem_wr_en <= wr_n;
      mem_data_in <= din_n;
    end
  end
endmodule

// File: tb/tb_better_neighbor_scan.sv
// tb_better_neighbor_scan: random and directed runs scored against a list-based reference model
module tb_better_neighbor_scan;
  import node_mem_pkg::*;
  typedef struct packed {
    logic [31:0] start_cyc;
    logic [31:0] lat;
    logic [4:0] cnt;
    logic ovf;
    logic [15:0][15:0] ids;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] own_q = '0;
  logic busy, done, overflow, mem_wr_en;
  logic [4:0] better_count;
  logic [15:0] mem_address, mem_data_in, mem_data_out;
  logic [7:0] mem [MEM_DEPTH];
  logic bd_we = 1'b0;
  logic [15:0] bd_addr = '0, bd_data = '0;
  logic [15:0] tq [64];
  logic [15:0] tid [64];
  logic [15:0] tcnt;
  exp_t exp_q [$];
  int cyc = 0, total = 0, bad = 0, wcnt = 0;
  always #5 clk = ~clk;
  better_neighbor_scan dut (
    .clock(clk), .reset(rst), .start(start), .own_q(own_q), .busy(busy), .done(done),
    .better_count(better_count), .overflow(overflow), .mem_address(mem_address),
    .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );
  assign mem_data_out = {mem[mem_address[10:0]], mem[mem_address[10:0] + 11'd1]};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      mem[mem_address[10:0]] <= mem_data_in[15:8];
      mem[mem_address[10:0] + 11'd1] <= mem_data_in[7:0];
    end
    if (bd_we) begin
      mem[bd_addr[10:0]] <= bd_data[15:8];
      mem[bd_addr[10:0] + 11'd1] <= bd_data[7:0];
    end
  end
  function automatic logic [15:0] rd(input logic [15:0] a);
    return {mem[a[10:0]], mem[a[10:0] + 11'd1]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask
  // reference: walk the clamped table, list every strictly better neighbour
  function automatic exp_t model(input logic [15:0] oq);
    exp_t e;
    int n, hits;
    e = '0;
    n = tcnt > 64 ? 64 : int'(tcnt);
    hits = 0;
    e.lat = 3;
    for (int j = 0; j < n; j++) begin
      if (tq[j] > oq) begin
        if (hits < 16) begin
          e.ids[hits] = tid[j];
          e.lat += 3;
        end else e.lat += 1;
        hits++;
      end else e.lat += 1;
    end
    e.cnt = hits > 16 ? 5'd16 : 5'(hits);
    e.ovf = hits > 16;
    return e;
  endfunction
  task automatic put(input logic [15:0] a, input logic [15:0] d);
    bd_addr = a;
    bd_data = d;
    @(negedge clk);
  endtask
  task automatic load();
    @(negedge clk);
    bd_we = 1'b1;
    for (int j = 0; j < 64; j++) put(BASE_QVALUE + 16'(2 * j), tq[j]);
    for (int j = 0; j < 64; j++) put(BASE_NBR_ID + 16'(2 * j), tid[j]);
    for (int j = 0; j < 16; j++) put(BASE_BETTER_NBR + 16'(2 * j), 16'hDE00 + 16'(j));
    put(BASE_NBR_CNT, tcnt);
    put(BASE_BETTER_CNT, 16'hBEEF);
    bd_we = 1'b0;
  endtask
  task automatic run(input logic [15:0] oq, input int mid);
    exp_t e;
    int k;
    e = model(oq);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    start = 1'b1;
    own_q = oq;
    @(negedge clk);
    start = 1'b0;
    own_q = 16'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    if (mid > 0) begin
      repeat (mid) @(negedge clk);
      start = 1'b1;
      own_q = 16'h0000;
      @(negedge clk);
      start = 1'b0;
    end
    for (k = 0; k < 1000 && done !== 1'b1; k++) @(negedge clk);
    if (done !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done, required done within 1000 cycles");
    end
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst) wcnt = 0;
    else begin
      if (mem_wr_en && mem_address >= BASE_BETTER_NBR && mem_address < BASE_BETTER_NBR + 16'd32) wcnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done, required none");
        end else begin
          e = exp_q.pop_front();
          check("latency", 32'(cyc) - e.start_cyc, e.lat);
          check("better_count", 32'(better_count), 32'(e.cnt));
          check("overflow", 32'(overflow), 32'(e.ovf));
          check("busy_at_done", 32'(busy), 32'd0);
          check("cnt_word", 32'(rd(BASE_BETTER_CNT)), {27'b0, e.cnt});
          check("nbr_cnt_intact", 32'(rd(BASE_NBR_CNT)), 32'(tcnt));
          check("bn_writes", 32'(wcnt), 32'(e.cnt));
          for (int j = 0; j < 16; j++)
            check($sformatf("bn[%0d]", j), 32'(rd(BASE_BETTER_NBR + 16'(2 * j))),
                  32'(j < int'(e.cnt) ? e.ids[j] : 16'hDE00 + 16'(j)));
        end
        wcnt = 0;
      end
    end
  end
  task automatic typical();
    tcnt = 16;
    for (int j = 0; j < 64; j++) begin
      tq[j] = j < 16 ? 16'(16 - j) : 16'd0;
      tid[j] = 16'(j);
    end
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(better_count), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_addr", 32'(mem_address), 0);
    check("rst_wr_en", 32'(mem_wr_en), 0);
    check("rst_data_in", 32'(mem_data_in), 0);
    rst = 1'b0;
    typical();
    load();
    run(16'd12, 0);
    run(16'd12, 0);
    load();
    run(16'd16, 0);
    tcnt = 20;
    for (int j = 16; j < 20; j++) tq[j] = 16'd50;
    load();
    run(16'd0, 0);
    tcnt = 0;
    load();
    run(16'd0, 0);
    typical();
    load();
    run(16'd12, 5);
    for (int r = 0; r < 8; r++) begin
      logic [15:0] oq;
      tcnt = r % 4 == 0 ? 16'($urandom_range(65, 300)) : 16'($urandom_range(1, 64));
      oq = r % 2 == 0 ? 16'($urandom) : 16'($urandom_range(0, 1300));
      for (int j = 0; j < 64; j++) begin
        tq[j] = r % 2 == 0 ? 16'($urandom) : 16'($urandom_range(0, 1300));
        tid[j] = 16'($urandom);
      end
      if (r == 3) tq[0] = oq;
      load();
      run(oq, 0);
    end
    typical();
    load();
    start = 1'b1;
    own_q = 16'd12;
    @(negedge clk);
    start = 1'b0;
    for (k = 0; k < 200 && !(mem_wr_en && mem_address == BASE_BETTER_NBR + 16'd2); k++) @(negedge clk);
    if (!(mem_wr_en && mem_address == BASE_BETTER_NBR + 16'd2)) begin
      total++;
      bad++;
      $display("FAIL second_wr_bn_timeout: got no second write, required one within 200 cycles");
    end
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wr_en", 32'(mem_wr_en), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    rst = 1'b0;
    check("midrst_entry0", 32'(rd(BASE_BETTER_NBR)), 32'(tid[0]));
    check("midrst_cnt_word", 32'(rd(BASE_BETTER_CNT)), 32'h0000BEEF);
    repeat (40) @(negedge clk);
    check("pending_expectations", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
